// File: rtl/mem_handle_responder.sv
// Scratchpad responder for four mem_handle initiators (a..d).
// Round-robin arbitration, registered done pulse and per-handle held read data.
module mem_handle_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_l,

    input  logic              a_r_en,
    input  logic              a_w_en,
    input  logic              a_avail,
    input  logic [PTR_W-1:0]  a_ptr,
    input  logic [31:0]       a_data_store,
    output logic              a_done,
    output logic [31:0]       a_data_load,

    input  logic              b_r_en,
    input  logic              b_w_en,
    input  logic              b_avail,
    input  logic [PTR_W-1:0]  b_ptr,
    input  logic [31:0]       b_data_store,
    output logic              b_done,
    output logic [31:0]       b_data_load,

    input  logic              c_r_en,
    input  logic              c_w_en,
    input  logic              c_avail,
    input  logic [PTR_W-1:0]  c_ptr,
    input  logic [31:0]       c_data_store,
    output logic              c_done,
    output logic [31:0]       c_data_load,

    input  logic              d_r_en,
    input  logic              d_w_en,
    input  logic              d_avail,
    input  logic [PTR_W-1:0]  d_ptr,
    input  logic [31:0]       d_data_store,
    output logic              d_done,
    output logic [31:0]       d_data_load
);

    // state   | meaning
    // IDLE    | waiting; grant an eligible handle and latch its request
    // ACCESS  | scratchpad read/write at the latched address
    // RESP    | done high on the granted handle, read data already loaded
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state_q, state_d;

    logic [3:0]          req;
    logic [3:0]          w_flag;
    logic [3:0]          eligible;
    logic [ADDR_W-1:0]   ptr_lo [4];
    logic [31:0]         wdata  [4];

    logic [1:0]          last_q;
    logic [1:0]          lat_idx;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [31:0]         lat_wdata;
    logic [3:0]          done_q;
    logic [31:0]         dl_q [4];

    logic                grant_vld;
    logic [1:0]          grant_idx;
    logic [1:0]          cand;
    logic                in_range;
    logic [31:0]         rd_word;

    logic [31:0]         mem [DEPTH];

    logic                unused_inputs;
    assign unused_inputs = ^{a_avail, b_avail, c_avail, d_avail,
                             a_ptr[PTR_W-1:ADDR_W], b_ptr[PTR_W-1:ADDR_W],
                             c_ptr[PTR_W-1:ADDR_W], d_ptr[PTR_W-1:ADDR_W]};

    assign req    = {d_r_en | d_w_en, c_r_en | c_w_en, b_r_en | b_w_en, a_r_en | a_w_en};
    assign w_flag = {d_w_en, c_w_en, b_w_en, a_w_en};
    assign ptr_lo[0] = a_ptr[ADDR_W-1:0];
    assign ptr_lo[1] = b_ptr[ADDR_W-1:0];
    assign ptr_lo[2] = c_ptr[ADDR_W-1:0];
    assign ptr_lo[3] = d_ptr[ADDR_W-1:0];
    assign wdata[0]  = a_data_store;
    assign wdata[1]  = b_data_store;
    assign wdata[2]  = c_data_store;
    assign wdata[3]  = d_data_store;

    // A request is still visible during its own done cycle and must not be re-accepted.
    assign eligible = req & ~done_q;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (grant_vld) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign in_range = int'(lat_addr) < DEPTH;
    assign rd_word  = in_range ? mem[lat_addr] : 32'h0;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= S_IDLE;
            last_q    <= 2'd3;
            lat_idx   <= 2'd0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'h0;
            done_q    <= 4'b0;
            for (int i = 0; i < 4; i++) dl_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            done_q  <= 4'b0;
            if (state_q == S_IDLE && grant_vld) begin
                last_q    <= grant_idx;
                lat_idx   <= grant_idx;
                lat_addr  <= ptr_lo[grant_idx];
                lat_we    <= w_flag[grant_idx];
                lat_wdata <= wdata[grant_idx];
            end
            if (state_q == S_ACCESS) begin
                done_q[lat_idx] <= 1'b1;
                if (!lat_we) dl_q[lat_idx] <= rd_word;
            end
        end
    end

    // Storage is deliberately unreset; an async reset during ACCESS pulls state to IDLE first.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && lat_we && in_range) mem[lat_addr] <= lat_wdata;
    end

    assign a_done      = done_q[0];
    assign b_done      = done_q[1];
    assign c_done      = done_q[2];
    assign d_done      = done_q[3];
    assign a_data_load = dl_q[0];
    assign b_data_load = dl_q[1];
    assign c_data_load = dl_q[2];
    assign d_data_load = dl_q[3];

endmodule

// File: tb/tb_mem_handle_responder.sv
// Directed bench for mem_handle_responder: vector table of single transactions
// plus hand-written arbitration, fairness and reset-abort sequences.
module tb_mem_handle_responder;

    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int PTR_W  = 32;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic [3:0]  r_en = '0;
    logic [3:0]  w_en = '0;
    logic [3:0]  avail = '0;
    logic [31:0] ptr [4];
    logic [31:0] dst [4];
    logic [3:0]  done;
    logic [31:0] dl [4];

    logic [31:0] exp_dl [4];
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    mem_handle_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .a_r_en       (r_en[0]), .a_w_en(w_en[0]), .a_avail(avail[0]),
        .a_ptr        (ptr[0]),  .a_data_store(dst[0]),
        .a_done       (done[0]), .a_data_load(dl[0]),
        .b_r_en       (r_en[1]), .b_w_en(w_en[1]), .b_avail(avail[1]),
        .b_ptr        (ptr[1]),  .b_data_store(dst[1]),
        .b_done       (done[1]), .b_data_load(dl[1]),
        .c_r_en       (r_en[2]), .c_w_en(w_en[2]), .c_avail(avail[2]),
        .c_ptr        (ptr[2]),  .c_data_store(dst[2]),
        .c_done       (done[2]), .c_data_load(dl[2]),
        .d_r_en       (r_en[3]), .d_w_en(w_en[3]), .d_avail(avail[3]),
        .d_ptr        (ptr[3]),  .d_data_store(dst[3]),
        .d_done       (done[3]), .d_data_load(dl[3])
    );

    typedef struct {
        int          h;
        logic        r;
        logic        w;
        logic [31:0] p;
        logic [31:0] d;
        logic [31:0] exp_load;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_loads(input string tag);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s data_load[%0d]", tag, j), dl[j], exp_dl[j]);
    endtask

    // Request at cycle N, done expected in N+2 only; inputs scrambled after the grant.
    task automatic run_txn(input int h, input logic r, input logic w, input logic [31:0] p,
                           input logic [31:0] d, input logic [31:0] el, input string tag);
        @(negedge clk);
        r_en[h] = r; w_en[h] = w; ptr[h] = p; dst[h] = d;
        @(negedge clk);
        chk({tag, " done N+1"}, {28'h0, done}, 32'h0);
        ptr[h] = p ^ 32'h1; dst[h] = ~d; w_en[h] = ~w;
        @(negedge clk);
        chk({tag, " done N+2"}, {28'h0, done}, 32'(4'b0001 << h));
        exp_dl[h] = el;
        chk_loads(tag);
        r_en[h] = 1'b0; w_en[h] = 1'b0;
        @(negedge clk);
        chk({tag, " done N+3"}, {28'h0, done}, 32'h0);
    endtask

    vec_t vecs [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_done;
        for (int i = 0; i < 4; i++) begin
            ptr[i] = '0; dst[i] = '0; exp_dl[i] = '0;
        end

        vecs[0]  = '{0, 1'b0, 1'b1, 32'd5,    32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 1'b1, 1'b0, 32'd5,    32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1, 1'b0, 1'b1, 32'd0,    32'd10,       32'h0};
        vecs[3]  = '{2, 1'b0, 1'b1, 32'd1,    32'd11,       32'h0};
        vecs[4]  = '{3, 1'b0, 1'b1, 32'd2,    32'd12,       32'h0};
        vecs[5]  = '{0, 1'b0, 1'b1, 32'd3,    32'd13,       32'hDEADBEEF};
        vecs[6]  = '{2, 1'b1, 1'b0, 32'd5,    32'h0,        32'hDEADBEEF};
        vecs[7]  = '{2, 1'b1, 1'b1, 32'd7,    32'h1234,     32'hDEADBEEF};
        vecs[8]  = '{2, 1'b1, 1'b0, 32'd7,    32'h0,        32'h1234};
        vecs[9]  = '{3, 1'b0, 1'b1, 32'd9,    32'h0000AAAA, 32'h0};
        vecs[10] = '{1, 1'b1, 1'b0, 32'd0,    32'h0,        32'd10};
        vecs[11] = '{1, 1'b0, 1'b1, DEPTH,    32'h55,       32'd10};
        vecs[12] = '{1, 1'b1, 1'b0, DEPTH,    32'h0,        32'h0};
        vecs[13] = '{0, 1'b1, 1'b0, 32'd3,    32'h0,        32'd13};
        vecs[14] = '{3, 1'b1, 1'b0, 32'd9,    32'h0,        32'h0000AAAA};

        @(negedge clk);
        chk("reset done", {28'h0, done}, 32'h0);
        chk_loads("reset");
        @(negedge clk);
        rst_l = 1'b1;

        for (int i = 0; i < 15; i++)
            run_txn(vecs[i].h, vecs[i].r, vecs[i].w, vecs[i].p, vecs[i].d,
                    vecs[i].exp_load, $sformatf("vec%0d", i));

        // Fresh reset so round-robin restarts from d; scratchpad keeps its contents.
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) exp_dl[j] = '0;
        chk("rst2 done", {28'h0, done}, 32'h0);
        chk_loads("rst2");
        @(negedge clk);
        rst_l = 1'b1;

        // Arbitration: all four read addresses 0..3 together.
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            r_en[j] = 1'b1; ptr[j] = 32'(j);
        end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            exp_done = (t == 2) ? 4'b0001 : (t == 5) ? 4'b0010 :
                       (t == 8) ? 4'b0100 : (t == 11) ? 4'b1000 : 4'b0000;
            chk($sformatf("arb done t%0d", t), {28'h0, done}, {28'h0, exp_done});
            for (int j = 0; j < 4; j++) if (exp_done[j]) r_en[j] = 1'b0;
        end
        for (int j = 0; j < 4; j++) exp_dl[j] = 32'(10 + j);
        chk_loads("arb");

        // Fairness: a requests continuously, b arrives once while a is in ACCESS.
        r_en[0] = 1'b1; ptr[0] = 32'd1;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            if (t == 1) begin
                r_en[1] = 1'b1; ptr[1] = 32'd2;
            end else begin
                exp_done = (t == 2) ? 4'b0001 : (t == 5) ? 4'b0010 :
                           (t == 8) ? 4'b0001 : 4'b0000;
                chk($sformatf("fair done t%0d", t), {28'h0, done}, {28'h0, exp_done});
                if (t == 5) r_en[1] = 1'b0;
                if (t == 8) r_en[0] = 1'b0;
            end
        end
        exp_dl[0] = 32'd11; exp_dl[1] = 32'd12;
        chk_loads("fair");

        // Reset during ACCESS of a write to 9: aborted, no done, old word kept.
        @(negedge clk);
        w_en[3] = 1'b1; ptr[3] = 32'd9; dst[3] = 32'hFFFF0000;
        @(negedge clk);
        rst_l = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) exp_dl[j] = '0;
        chk("midrst done", {28'h0, done}, 32'h0);
        chk_loads("midrst");
        w_en[3] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk($sformatf("midrst hold done %0d", t), {28'h0, done}, 32'h0);
        end
        rst_l = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk($sformatf("postrst done %0d", t), {28'h0, done}, 32'h0);
        end
        run_txn(0, 1'b1, 1'b0, 32'd9, 32'h0, 32'h0000AAAA, "read9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
